// File: rtl/vid_pack_pkg.sv
// vid_pack_pkg -- shared definitions for the video beat packer.
// Holds the register map, the packer state enumeration, the FIFO word
// layout and the HSIZE sanitising helper used on register writes.
package vid_pack_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_HSIZE  = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_FCNT   = 8'h0C;

  localparam int HSIZE_DEFAULT = 640;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_DROP
  } state_t;

  // One output word as stored in the FIFO: 64 data bits + tuser + tlast.
  typedef struct packed {
    logic [63:0] data;
    logic        user;
    logic        last;
  } word_t;

  // Lines must hold an even, nonzero number of beats so that every line
  // ends on a complete 64-bit word.
  function automatic logic [11:0] hsize_fix(input logic [11:0] v);
    logic [11:0] e;
    e = {v[11:1], 1'b0};
    return (e == 12'd0) ? 12'd2 : e;
  endfunction

endpackage

// File: rtl/vid_pack_if.sv
// vid_pack_if -- bundles the register bus, the video beat input and the
// AXI-Stream output of vid_pack.
//   slave  : view of vid_pack (register-bus slave, beat sink, stream source)
//   master : view of whatever drives the block (CPU/video source/DMA side)
interface vid_pack_if;
  logic        ibus_cs;
  logic        ibus_wr;
  logic [7:0]  ibus_addr;
  logic [31:0] ibus_wrdata;
  logic [31:0] ibus_rddata;

  logic        sof_in;
  logic        vin;
  logic [15:0] d1_in;
  logic [15:0] d2_in;

  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic [63:0] m_tdata;

  modport slave (
    input  ibus_cs, ibus_wr, ibus_addr, ibus_wrdata,
    output ibus_rddata,
    input  sof_in, vin, d1_in, d2_in,
    output m_tvalid, m_tuser, m_tlast, m_tdata,
    input  m_tready
  );

  modport master (
    output ibus_cs, ibus_wr, ibus_addr, ibus_wrdata,
    input  ibus_rddata,
    output sof_in, vin, d1_in, d2_in,
    input  m_tvalid, m_tuser, m_tlast, m_tdata,
    output m_tready
  );
endinterface

// File: rtl/vid_pack_fifo.sv
// vid_pack_fifo -- synchronous show-ahead FIFO.
// Storage is an array with a registered read; the read register is the
// show-ahead head, so a written word appears on rd_data/!empty two edges
// after wr_en. DEPTH counts every stored word, head register included.
//   clk, rst       : clock, asynchronous active-high reset
//   wr_en, wr_data : push request (ignored when full unless popping)
//   rd_en          : pop the head word when !empty
//   rd_data        : head word
//   full, empty    : occupancy flags
module vid_pack_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      ram_cnt, total_cnt;
  logic [WIDTH-1:0] dout_reg;
  logic             dout_vld_reg;
  logic             pop, push, load;

  assign ram_cnt   = wr_ptr_reg - rd_ptr_reg;
  assign total_cnt = ram_cnt + {{AW{1'b0}}, dout_vld_reg};
  assign full      = (total_cnt == (AW+1)'(DEPTH));
  assign pop       = rd_en & dout_vld_reg;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = wr_en & (~full | pop);
  // Refill the head whenever it is empty or being consumed.
  assign load      = (ram_cnt != '0) & (~dout_vld_reg | pop);

  assign rd_data = dout_reg;
  assign empty   = ~dout_vld_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) begin
        dout_reg   <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      dout_vld_reg <= load | (dout_vld_reg & ~pop);
    end
  end
endmodule

// File: rtl/vid_pack.sv
// vid_pack -- packs pairs of 32-bit video beats into 64-bit AXI-Stream
// words (first beat in the low half), marks frame start (tuser) and line
// end (tlast), and buffers words in an output FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.ibus_* : register bus (CTRL, HSIZE, STATUS, FCNT), registered read
//   bus.sof_in, bus.vin, bus.d1_in, bus.d2_in : beat input, no back-pressure
//   bus.m_t*   : AXI-Stream master toward DMA
// Params: FIFO_DEPTH (power of two, >= 4), HSIZE_RST (beats per line).
module vid_pack
  import vid_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HSIZE_RST  = HSIZE_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  vid_pack_if.slave  bus
);
  state_t      state_reg, state_next;
  logic        en_reg, ovf_reg;
  logic [11:0] hsize_reg, hsize_lat_reg, beat_cnt_reg;
  logic [15:0] fcnt_reg;
  logic [31:0] rddata_reg, rd_mux, half_reg, beat_data;
  logic        have_a_reg, first_reg, last_pushed_reg;
  logic        push_vld_reg;
  word_t       push_word_reg, fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        start, pack_beat, fcnt_inc;
  logic        sof_beat, pop, overflow, push_ok, frame_done, busy, word_last;
  logic        wr_strobe, ovf_clr;
  logic        unused_wrdata;

  assign beat_data  = {bus.d2_in, bus.d1_in};
  assign sof_beat   = bus.sof_in & bus.vin;
  assign pop        = ~fifo_empty & bus.m_tready;
  assign overflow   = push_vld_reg & fifo_full & ~pop;
  assign push_ok    = push_vld_reg & ~overflow;
  // A tlast word pushed on this very edge also completes the frame.
  assign frame_done = last_pushed_reg | (push_ok & push_word_reg.last);
  assign busy       = (state_reg != ST_IDLE) | ~fifo_empty;
  assign word_last  = (beat_cnt_reg == hsize_lat_reg - 12'd1);

  assign wr_strobe     = bus.ibus_cs & bus.ibus_wr;
  assign ovf_clr       = wr_strobe & (bus.ibus_addr == ADDR_STATUS) & bus.ibus_wrdata[0];
  assign unused_wrdata = ^bus.ibus_wrdata[31:12];

  vid_pack_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(word_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_vld_reg),
    .wr_data (push_word_reg),
    .rd_en   (bus.m_tready),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.m_tvalid    = ~fifo_empty;
  assign bus.m_tdata     = fifo_dout.data;
  assign bus.m_tuser     = fifo_dout.user;
  assign bus.m_tlast     = fifo_dout.last;
  assign bus.ibus_rddata = rddata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // A sof beat always wins: it restarts the frame from any state.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    pack_beat  = 1'b0;
    fcnt_inc   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sof_beat && en_reg) begin
          state_next = ST_PACK;
          start      = 1'b1;
        end
      end
      ST_PACK: begin
        if (sof_beat) begin
          fcnt_inc   = frame_done;
          start      = en_reg;
          state_next = en_reg ? ST_PACK : ST_IDLE;
        end else if (overflow) begin
          state_next = ST_DROP;
        end else if (bus.vin) begin
          pack_beat  = 1'b1;
        end
      end
      ST_DROP: begin
        if (sof_beat) begin
          start      = en_reg;
          state_next = en_reg ? ST_PACK : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat pairing: the sof beat is always beat A of the first word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_reg        <= '0;
      have_a_reg      <= 1'b0;
      beat_cnt_reg    <= '0;
      hsize_lat_reg   <= '0;
      first_reg       <= 1'b0;
      last_pushed_reg <= 1'b0;
      push_vld_reg    <= 1'b0;
      push_word_reg   <= '0;
    end else begin
      push_vld_reg <= 1'b0;
      if (push_ok && push_word_reg.last) last_pushed_reg <= 1'b1;
      if (start) begin
        half_reg        <= beat_data;
        have_a_reg      <= 1'b1;
        beat_cnt_reg    <= 12'd1;
        first_reg       <= 1'b1;
        last_pushed_reg <= 1'b0;
        hsize_lat_reg   <= hsize_reg;
      end else if (pack_beat) begin
        if (!have_a_reg) begin
          half_reg     <= beat_data;
          have_a_reg   <= 1'b1;
          beat_cnt_reg <= beat_cnt_reg + 12'd1;
        end else begin
          push_vld_reg  <= 1'b1;
          push_word_reg <= '{data: {beat_data, half_reg}, user: first_reg, last: word_last};
          have_a_reg    <= 1'b0;
          first_reg     <= 1'b0;
          beat_cnt_reg  <= word_last ? 12'd0 : beat_cnt_reg + 12'd1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.ibus_addr)
      ADDR_CTRL:   rd_mux[0]     = en_reg;
      ADDR_HSIZE:  rd_mux[11:0]  = hsize_reg;
      ADDR_STATUS: rd_mux[1:0]   = {busy, ovf_reg};
      ADDR_FCNT:   rd_mux[15:0]  = fcnt_reg;
      default:     rd_mux        = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg     <= 1'b0;
      hsize_reg  <= 12'(HSIZE_RST);
      ovf_reg    <= 1'b0;
      fcnt_reg   <= '0;
      rddata_reg <= '0;
    end else begin
      if (wr_strobe && bus.ibus_addr == ADDR_CTRL)  en_reg <= bus.ibus_wrdata[0];
      if (wr_strobe && bus.ibus_addr == ADDR_HSIZE) hsize_reg <= hsize_fix(bus.ibus_wrdata[11:0]);
      // A fresh overflow beats a simultaneous write-1-clear.
      ovf_reg <= overflow | (ovf_reg & ~ovf_clr);
      if (fcnt_inc) fcnt_reg <= fcnt_reg + 16'd1;
      if (bus.ibus_cs) rddata_reg <= rd_mux;
    end
  end
endmodule

// File: tb/tb_vid_pack.sv
module tb_vid_pack;
  import vid_pack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vid_pack_if vif();

  vid_pack #(.FIFO_DEPTH(16), .HSIZE_RST(640)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rx_count    = 0;
  logic [65:0] exp_q[$];
  logic [65:0] cur, prev_word, exp_w;
  logic        hold_prev = 1'b0;

  assign cur = {vif.m_tdata, vif.m_tuser, vif.m_tlast};

  function automatic logic [65:0] mk(input int a, input int b, input int base,
                                     input logic user, input logic last);
    logic [15:0] a1, a2, b1, b2;
    a1 = 16'(a); a2 = 16'(base + a);
    b1 = 16'(b); b2 = 16'(base + b);
    return {b2, b1, a2, a1, user, last};
  endfunction

  // Output monitor: scoreboard pop on every transfer, plus stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          vectors++;
          if ({vif.m_tvalid, cur} !== {1'b1, prev_word}) begin
            miscompares++;
            $display("FAIL stall_stable: got valid=%b word=%h required valid=1 word=%h",
                     vif.m_tvalid, cur, prev_word);
          end
        end
        if (vif.m_tvalid === 1'b1 && vif.m_tready === 1'b1) begin
          rx_count++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %h required no word", cur);
          end else begin
            exp_w = exp_q.pop_front();
            if (cur !== exp_w) begin
              miscompares++;
              $display("FAIL word: got %h required %h", cur, exp_w);
            end else begin
              $display("word %0d ok: data=%h user=%b last=%b", rx_count,
                       vif.m_tdata, vif.m_tuser, vif.m_tlast);
            end
          end
        end
        hold_prev = (vif.m_tvalid === 1'b1 && vif.m_tready === 1'b0);
        prev_word = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    vif.ibus_cs = 1'b1; vif.ibus_wr = 1'b1; vif.ibus_addr = a; vif.ibus_wrdata = d;
    tick();
    vif.ibus_cs = 1'b0; vif.ibus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    vif.ibus_cs = 1'b1; vif.ibus_wr = 1'b0; vif.ibus_addr = a;
    tick();
    vif.ibus_cs = 1'b0;
    d = vif.ibus_rddata;
  endtask

  task automatic beat(input logic s, input int k, input int base);
    vif.vin = 1'b1; vif.sof_in = s;
    vif.d1_in = 16'(k); vif.d2_in = 16'(base + k);
    tick();
    vif.vin = 1'b0; vif.sof_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [7:0]  addrs [4];
    logic [31:0] exps  [4];
    addrs = '{ADDR_CTRL, ADDR_HSIZE, ADDR_STATUS, ADDR_FCNT};
    exps  = '{32'd0, 32'd640, 32'd0, 32'd0};
    vectors++;
    if ({vif.m_tvalid, vif.m_tuser, vif.m_tlast, vif.m_tdata, vif.ibus_rddata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b u=%b l=%b d=%h rd=%h required all 0",
               vif.m_tvalid, vif.m_tuser, vif.m_tlast, vif.m_tdata, vif.ibus_rddata);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      vectors++;
      if (rd !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_reg%0h: got %h required %h", addrs[i], rd, exps[i]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_hsize_reg();
    logic [31:0] rd;
    logic [31:0] wv [4];
    logic [31:0] ev [4];
    wv = '{32'd7, 32'd0, 32'd1, 32'd4};
    ev = '{32'd6, 32'd2, 32'd2, 32'd4};
    for (int i = 0; i < 4; i++) begin
      bus_write(ADDR_HSIZE, wv[i]);
      bus_read(ADDR_HSIZE, rd);
      vectors++;
      if (rd !== ev[i]) begin
        miscompares++;
        $display("FAIL hsize_write_%0d: got %0d required %0d", wv[i], rd, ev[i]);
      end
    end
    $display("test_hsize_reg done");
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int rx0;
    bus_write(ADDR_HSIZE, 32'd4);
    bus_write(ADDR_CTRL, 32'd1);
    vif.m_tready = 1'b1;
    rx0 = rx_count;
    for (int w = 0; w < 4; w++)
      exp_q.push_back(mk(2*w+1, 2*w+2, 'h100, w == 0, (w % 2) == 1));
    for (int k = 1; k <= 8; k++) beat(k == 1, k, 'h100);
    bus_write(ADDR_CTRL, 32'd0);
    beat(1'b1, 'h55, 'h100);          // next sof closes the frame
    wait_drain("basic");
    vectors++;
    if (rx_count - rx0 !== 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d required 4", rx_count - rx0);
    end
    bus_read(ADDR_FCNT, rd);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++;
      $display("FAIL basic_fcnt: got %0d required 1", rd);
    end
    bus_read(ADDR_STATUS, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL basic_status: got %h required 0", rd);
    end
    $display("test_basic done");
  endtask

  task automatic test_latency();
    logic expv [3];
    expv = '{1'b0, 1'b0, 1'b1};
    bus_write(ADDR_HSIZE, 32'd2);
    bus_write(ADDR_CTRL, 32'd1);
    exp_q.push_back(mk(1, 2, 'h300, 1'b1, 1'b1));
    beat(1'b1, 1, 'h300);
    beat(1'b0, 2, 'h300);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (vif.m_tvalid !== expv[i]) begin
        miscompares++;
        $display("FAIL latency_cycle%0d: got tvalid=%b required %b", i, vif.m_tvalid, expv[i]);
      end
    end
    tick();
    wait_drain("latency");
    $display("test_latency done");
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int rx0;
    bus_write(ADDR_HSIZE, 32'd8);
    vif.m_tready = 1'b0;
    for (int w = 0; w < 16; w++)
      exp_q.push_back(mk(2*w+1, 2*w+2, 'h200, w == 0, (w % 4) == 3));
    for (int k = 1; k <= 40; k++) beat(k == 1, k, 'h200);
    tick(); tick(); tick();
    bus_read(ADDR_STATUS, rd);
    vectors++;
    if (rd !== 32'd3) begin
      miscompares++;
      $display("FAIL ovf_status: got %h required 3", rd);
    end
    rx0 = rx_count;
    vif.m_tready = 1'b1;
    wait_drain("overflow");
    vectors++;
    if (rx_count - rx0 !== 16) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d required 16", rx_count - rx0);
    end
    for (int k = 50; k < 54; k++) beat(1'b0, k, 'h200);
    tick(); tick(); tick();
    vectors++;
    if (vif.m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_discard: got tvalid=%b required 0", vif.m_tvalid);
    end
    bus_write(ADDR_STATUS, 32'd1);
    bus_read(ADDR_STATUS, rd);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL ovf_w1c: got %h required 2", rd);
    end
    $display("test_overflow done");
  endtask

  task automatic test_restart();
    bus_write(ADDR_HSIZE, 32'd4);
    vif.m_tready = 1'b1;
    exp_q.push_back(mk(1, 2, 'h400, 1'b1, 1'b0));
    exp_q.push_back(mk(11, 12, 'h400, 1'b1, 1'b0));
    exp_q.push_back(mk(13, 14, 'h400, 1'b0, 1'b1));
    beat(1'b1, 1, 'h400);
    beat(1'b0, 2, 'h400);
    beat(1'b0, 3, 'h400);
    for (int k = 11; k <= 14; k++) beat(k == 11, k, 'h400);
    wait_drain("restart");
    $display("test_restart done");
  endtask

  task automatic test_enable();
    logic [31:0] rd;
    bus_write(ADDR_CTRL, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) bus_write(ADDR_CTRL, 32'd1);
      beat(k == 1, k, 'h500);
      vectors++;
      if (vif.m_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_idle_beat%0d: got tvalid=%b required 0", k, vif.m_tvalid);
      end
    end
    tick(); tick(); tick();
    bus_read(ADDR_STATUS, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL en_idle_status: got %h required 0", rd);
    end
    exp_q.push_back(mk(9, 10, 'h500, 1'b1, 1'b0));
    exp_q.push_back(mk(11, 12, 'h500, 1'b0, 1'b1));
    for (int k = 9; k <= 12; k++) beat(k == 9, k, 'h500);
    wait_drain("enable");
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [7:0]  addrs [4];
    logic [31:0] exps  [4];
    int rx0;
    addrs = '{ADDR_CTRL, ADDR_HSIZE, ADDR_STATUS, ADDR_FCNT};
    exps  = '{32'd0, 32'd640, 32'd0, 32'd0};
    vif.m_tready = 1'b0;
    for (int k = 1; k <= 10; k++) beat(k == 1, k, 'h600);
    tick(); tick(); tick();
    vectors++;
    if (vif.m_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_queued: got tvalid=%b required 1", vif.m_tvalid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({vif.m_tvalid, vif.m_tdata} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_out: got tvalid=%b data=%h required 0", vif.m_tvalid, vif.m_tdata);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      vectors++;
      if (rd !== exps[i]) begin
        miscompares++;
        $display("FAIL rstmid_reg%0h: got %h required %h", addrs[i], rd, exps[i]);
      end
    end
    vif.m_tready = 1'b1;
    rx0 = rx_count;
    bus_write(ADDR_CTRL, 32'd1);
    for (int k = 20; k < 26; k++) beat(1'b0, k, 'h600);
    tick(); tick(); tick();
    vectors++;
    if (rx_count !== rx0 || vif.m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_nosof: got %0d words tvalid=%b required 0 words", rx_count - rx0, vif.m_tvalid);
    end
    exp_q.push_back(mk(1, 2, 'h600, 1'b1, 1'b0));
    beat(1'b1, 1, 'h600);
    beat(1'b0, 2, 'h600);
    wait_drain("rstmid");
    $display("test_reset_mid done");
  endtask

  initial begin
    vif.ibus_cs = 1'b0; vif.ibus_wr = 1'b0; vif.ibus_addr = '0; vif.ibus_wrdata = '0;
    vif.sof_in = 1'b0; vif.vin = 1'b0; vif.d1_in = '0; vif.d2_in = '0;
    vif.m_tready = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_hsize_reg();
    test_basic();
    test_latency();
    test_overflow();
    test_restart();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
